ps2_rx: RTL and testbench
=========================

PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8, meaning consecutive identical CLK samples required before filtered PS2_CLK changes (range 2..31).
REQ-002 Parameter TIMEOUT_CYCLES, default 16000, meaning CLK cycles without a filtered falling edge before an open frame is abandoned.
REQ-003 CLK  input  1  system clock; all logic on rising edge.
REQ-004 nRESET  input  1  reset, asynchronous, active-low.
REQ-005 PS2_CLK  input  1  raw keyboard clock pin, asynchronous to CLK.
REQ-006 PS2_DATA  input  1  raw keyboard data pin, asynchronous to CLK.
REQ-007 DATA  output  8  last correctly received scan-code byte.
REQ-008 VALID  output  1  one-cycle strobe: DATA updated with a new byte this cycle.
REQ-009 ERROR  output  1  one-cycle strobe: frame discarded (parity, stop, or timeout).
REQ-010 BUSY  output  1  high while a frame is in progress (state not IDLE).

Function
REQ-011 PS2_CLK and PS2_DATA shall each pass through a 2-flop synchroniser, with reset value 1.
REQ-012 Filtered clock shall change only after FILTER_LEN consecutive synchronised samples differ from its current value; shorter pulses shall have no effect.
REQ-013 A falling edge of the filtered clock shall produce a one-cycle internal strobe, during which the synchronised PS2_DATA is sampled.
REQ-014 States: IDLE, DATA, PARITY, STOP; transitions occur only on the sample strobe or on timeout.
REQ-015 IDLE: sampled 0 -> DATA with bit count 0; sampled 1 -> stay IDLE, with no strobe.
REQ-016 DATA: shift sampled bit in LSB-first; after the 8th bit -> PARITY.
REQ-017 PARITY: capture the bit; go to STOP.
REQ-018 STOP: if the stop bit = 1 and the 9 data+parity bits contain an odd number of ones -> DATA <= byte, VALID = 1 for the next cycle; otherwise ERROR = 1 for the next cycle with DATA unchanged; then go to IDLE.
REQ-019 Latency: VALID/ERROR shall assert exactly FILTER_LEN+3 CLK cycles after the first CLK edge at which the raw stop-bit falling PS2_CLK level is sampled low.
REQ-020 Timeout: in any state other than IDLE, a counter of cycles since the last strobe reaching TIMEOUT_CYCLES shall force IDLE and pulse ERROR for one cycle; in IDLE the counter shall be held at 0.
REQ-021 VALID and ERROR shall never be high in the same cycle; each shall be high for at most one cycle per frame.
REQ-022 DATA shall remain stable between VALID pulses, including across errors and timeouts.
REQ-023 Back-to-back frames with no idle gap beyond the stop bit shall all be received.
REQ-024 The block shall never drive the PS/2 lines (receive-only).

Reset
REQ-025 While nRESET is low: state IDLE, DATA = 0x00, VALID = 0, ERROR = 0, BUSY = 0, synchronisers and filtered clock = 1, counters = 0.
REQ-026 Reset asserted mid-frame shall discard the partial frame without an ERROR pulse; the first frame after release shall be received normally.

Structure
REQ-027 The shared package shall hold the state encoding, the default FILTER_LEN and TIMEOUT_CYCLES values, and the frame-length constant (11).
REQ-028 Synchroniser plus glitch filter shall be a sub-module, ps2_filter, instantiated once for PS2_CLK; PS2_DATA shall use a plain 2-flop synchroniser.

Verification
REQ-029 Frame 0x1C (parity 0, stop 1) -> one VALID pulse, DATA = 0x1C, ERROR = 0, BUSY low after the frame.
REQ-030 Frame 0xF0 with parity bit 0 -> one ERROR pulse, no VALID, DATA still holds the previous 0x1C.
REQ-031 Start bit plus 4 data bits, then idle -> ERROR exactly TIMEOUT_CYCLES after the last edge; a following 0x29 frame -> VALID, DATA = 0x29.
REQ-032 3-cycle low glitch on PS2_CLK (FILTER_LEN = 8) during IDLE and mid-frame -> no bit consumed; 0x75 is subsequently received correctly.
REQ-033 Back-to-back E0, F0, 75 -> three VALID pulses with DATA = 0xE0, 0xF0, 0x75 in order, each at the REQ-019 latency.
REQ-034 nRESET pulsed after the 5th bit of a frame -> no ERROR, outputs at reset values; the next frame 0x5A -> VALID, DATA = 0x5A.

Source files
------------

// File: rtl/ps2_rx_pkg.sv
// Shared constants and FSM encoding for the PS/2 receiver.
package ps2_rx_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  localparam int FILTER_LEN_DEF = 8;
  localparam int TIMEOUT_DEF    = 16000;
  localparam int FRAME_LEN      = 11;
endpackage

// File: rtl/ps2_filter.sv
// 2-flop synchroniser plus run-length glitch filter for the PS/2 clock line.
module ps2_filter
  import ps2_rx_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic i_raw,
  output logic o_filt
);
  localparam logic [4:0] CNT_MAX = 5'(FILTER_LEN - 1);

  logic       r_s1, r_s2, r_filt;
  logic [4:0] r_cnt;

  // r_cnt counts consecutive synchronised samples that disagree with r_filt;
  // any agreeing sample restarts the run, so short pulses are dropped.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_filt <= 1'b1;
      r_cnt  <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 != r_filt) begin
        if (r_cnt == CNT_MAX) begin
          r_filt <= r_s2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 5'd1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_filt = r_filt;
endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: filtered clock, frame FSM, odd parity/stop check, timeout.
module ps2_rx
  import ps2_rx_pkg::*;
#(
  parameter int FILTER_LEN     = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       ERROR,
  output logic       BUSY
);
  localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic          w_filt, w_fall, w_tmo_hit;
  logic          r_filt_d, r_strb, r_d1, r_d2;
  state_t        r_state, w_state_nxt;
  logic [2:0]    r_bitcnt, w_bitcnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt, r_data, w_data_nxt;
  logic          r_par, w_par_nxt;
  logic          r_valid, w_valid_nxt, r_error, w_error_nxt;
  logic [TW-1:0] r_tmo;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .CLK    (CLK),
    .nRESET (nRESET),
    .i_raw  (PS2_CLK),
    .o_filt (w_filt)
  );

  assign w_fall = r_filt_d & ~w_filt;

  // Registered strobe; data sync is far ahead of the clock, so r_d2 is settled.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_d1     <= 1'b1;
      r_d2     <= 1'b1;
      r_filt_d <= 1'b1;
      r_strb   <= 1'b0;
    end else begin
      r_d1     <= PS2_DATA;
      r_d2     <= r_d1;
      r_filt_d <= w_filt;
      r_strb   <= w_fall;
    end
  end

  assign w_tmo_hit = (r_state != ST_IDLE) && !r_strb && (r_tmo == TMO_MAX);

  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_par_nxt    = r_par;
    w_data_nxt   = r_data;
    w_valid_nxt  = 1'b0;
    w_error_nxt  = 1'b0;
    if (w_tmo_hit) begin
      w_state_nxt = ST_IDLE;
      w_error_nxt = 1'b1;
    end else if (r_strb) begin
      case (r_state)
        ST_IDLE: begin
          if (!r_d2) begin
            w_state_nxt  = ST_DATA;
            w_bitcnt_nxt = 3'd0;
          end
        end
        ST_DATA: begin
          w_shift_nxt  = {r_d2, r_shift[7:1]};
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          w_par_nxt   = r_d2;
          w_state_nxt = ST_STOP;
        end
        ST_STOP: begin
          if (r_d2 && (^{r_shift, r_par})) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
          end else begin
            w_error_nxt = 1'b1;
          end
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
      r_tmo    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_par    <= w_par_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_error  <= w_error_nxt;
      if (w_state_nxt == ST_IDLE || r_strb) r_tmo <= '0;
      else                                  r_tmo <= r_tmo + TW'(1);
    end
  end

  assign DATA  = r_data;
  assign VALID = r_valid;
  assign ERROR = r_error;
  assign BUSY  = (r_state != ST_IDLE);
endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: driver queues expected pulses, monitor checks them.
module tb_ps2_rx;
  localparam int F    = 8;
  localparam int T    = 200;
  localparam int HALF = 20;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic [7:0] DATA;
  logic       VALID, ERROR, BUSY;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] last_good = 8'h00;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
    int         cyc;
  } exp_t;
  exp_t q[$];

  ps2_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .nRESET(nRESET), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .DATA(DATA), .VALID(VALID), .ERROR(ERROR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every VALID/ERROR pulse must match the head of the queue.
  always @(negedge CLK) begin
    if (nRESET === 1'b1 && (VALID === 1'b1 || ERROR === 1'b1)) begin
      check("valid_error_exclusive", {31'd0, VALID & ERROR}, 32'd0);
      if (q.size() == 0) begin
        check("unexpected_pulse", {31'd0, ERROR}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_kind_error", {31'd0, ERROR}, {31'd0, e.is_err});
        check("pulse_data", {24'd0, DATA}, {24'd0, e.d});
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  // One PS/2 bit; optionally queue the pulse this falling edge should cause.
  task automatic ps2_bit(input logic b, input bit push, input bit is_err,
                         input logic [7:0] d, input int extra);
    exp_t e;
    PS2_DATA = b;
    repeat (HALF) @(negedge CLK);
    PS2_CLK = 1'b0;
    if (push) begin
      e.is_err = is_err; e.d = d; e.cyc = cyc + F + 4 + extra;
      q.push_back(e);
    end
    repeat (HALF) @(negedge CLK);
    PS2_CLK = 1'b1;
  endtask

  task automatic glitch();
    repeat (12) @(negedge CLK);
    PS2_CLK = 1'b0;
    repeat (3) @(negedge CLK);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int glitch_after);
    logic [10:0] bits;
    bit ok;
    logic [7:0] d;
    ok = stp && (^{b, par});
    if (ok) last_good = b;
    d = last_good;
    bits = {stp, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_bit(bits[i], i == 10, !ok, d, 0);
      if (i == glitch_after) glitch();
    end
  endtask

  task automatic partial(input int nbits, input bit expect_tmo);
    logic [7:0] pat;
    pat = 8'b0101_0110;
    ps2_bit(1'b0, nbits == 1 && expect_tmo, 1'b1, last_good, T);
    for (int i = 1; i < nbits; i++)
      ps2_bit(pat[i-1], (i == nbits - 1) && expect_tmo, 1'b1, last_good, T);
  endtask

  initial begin
    repeat (4) @(negedge CLK);
    check("reset_data", {24'd0, DATA}, 32'h00);
    check("reset_valid", {31'd0, VALID}, 32'd0);
    check("reset_error", {31'd0, ERROR}, 32'd0);
    check("reset_busy", {31'd0, BUSY}, 32'd0);
    nRESET = 1'b1;
    repeat (10) @(negedge CLK);

    send_frame(8'h1C, 1'b0, 1'b1, -1);
    repeat (30) @(negedge CLK);
    check("busy_after_1C", {31'd0, BUSY}, 32'd0);
    check("data_1C", {24'd0, DATA}, 32'h1C);

    send_frame(8'hF0, 1'b0, 1'b1, -1);
    repeat (30) @(negedge CLK);
    check("data_held_after_parity_err", {24'd0, DATA}, 32'h1C);

    partial(5, 1'b1);
    check("busy_mid_frame", {31'd0, BUSY}, 32'd1);
    repeat (T + 30) @(negedge CLK);
    check("busy_after_timeout", {31'd0, BUSY}, 32'd0);
    check("data_held_after_timeout", {24'd0, DATA}, 32'h1C);

    send_frame(8'h29, 1'b0, 1'b1, -1);
    repeat (30) @(negedge CLK);

    PS2_DATA = 1'b0;
    repeat (5) @(negedge CLK);
    glitch();
    repeat (20) @(negedge CLK);
    check("busy_after_idle_glitch", {31'd0, BUSY}, 32'd0);
    send_frame(8'h75, 1'b0, 1'b1, 3);
    repeat (30) @(negedge CLK);

    send_frame(8'hE0, 1'b0, 1'b1, -1);
    send_frame(8'hF0, 1'b1, 1'b1, -1);
    send_frame(8'h75, 1'b0, 1'b1, -1);
    repeat (30) @(negedge CLK);

    partial(5, 1'b0);
    check("busy_before_reset", {31'd0, BUSY}, 32'd1);
    repeat (5) @(negedge CLK);
    nRESET = 1'b0;
    #1;
    check("midreset_data", {24'd0, DATA}, 32'h00);
    check("midreset_busy", {31'd0, BUSY}, 32'd0);
    repeat (3) @(negedge CLK);
    nRESET = 1'b1;
    last_good = 8'h00;
    repeat (10) @(negedge CLK);
    send_frame(8'h5A, 1'b1, 1'b1, -1);
    repeat (T + 30) @(negedge CLK);
    check("data_5A", {24'd0, DATA}, 32'h5A);
    check("missing_pulses", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
